// File: rtl/leaf_user_rr_merge.sv
// rtl/leaf_user_rr_merge.sv - round-robin merge of NUM_IN vld/ack streams with burst lock and source tag
module leaf_user_rr_merge #(
    parameter int NUM_IN       = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int SRC_BITS     = 2,
    parameter int MAX_BURST    = 4,
    parameter int CNT_BITS     = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN*PAYLOAD_BITS-1:0] din_leaf_interface2user,
    input  logic [NUM_IN-1:0]              vld_interface2user,
    output logic [NUM_IN-1:0]              ack_user2interface,
    output logic [PAYLOAD_BITS-1:0]        dout_merge,
    output logic [SRC_BITS-1:0]            src_merge,
    output logic                           vld_merge,
    input  logic                           ack_merge,
    output logic [CNT_BITS-1:0]            beat_count
);

    localparam int BW = $clog2(MAX_BURST + 1);

    logic [PAYLOAD_BITS-1:0] w_din [NUM_IN];
    logic                    w_accept;
    logic                    w_any;
    logic                    w_lock;
    logic                    w_xfer;
    logic [SRC_BITS-1:0]     w_grant;
    logic [SRC_BITS-1:0]     w_idx;

    logic [SRC_BITS-1:0]     r_last;
    logic [BW-1:0]           r_burst;
    logic [PAYLOAD_BITS-1:0] r_dout;
    logic [SRC_BITS-1:0]     r_src;
    logic                    r_vld;
    logic [CNT_BITS-1:0]     r_beat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign w_din[gi] = din_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    endgenerate

    assign w_accept = ~r_vld | ack_merge;
    assign w_any    = |vld_interface2user;
    assign w_xfer   = w_accept & w_any;
    assign w_lock   = vld_interface2user[r_last] && (r_burst != '0) && (r_burst < BW'(MAX_BURST));

    // Scan from farthest to nearest so the nearest valid port after last wins.
    always_comb begin
        w_grant = r_last;
        w_idx   = '0;
        if (!w_lock) begin
            for (int k = NUM_IN; k >= 1; k--) begin
                w_idx = SRC_BITS'((int'(r_last) + k) % NUM_IN);
                if (vld_interface2user[w_idx]) w_grant = w_idx;
            end
        end
    end

    always_comb begin
        ack_user2interface = '0;
        if (w_xfer && !reset) ack_user2interface[w_grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last  <= SRC_BITS'(NUM_IN - 1);
            r_burst <= '0;
            r_dout  <= '0;
            r_src   <= '0;
            r_vld   <= 1'b0;
            r_beat  <= '0;
        end else if (w_accept) begin
            if (w_any) begin
                r_dout  <= w_din[w_grant];
                r_src   <= w_grant;
                r_vld   <= 1'b1;
                r_last  <= w_grant;
                r_burst <= w_lock ? r_burst + 1'b1 : BW'(1);
                r_beat  <= r_beat + 1'b1;
            end else begin
                r_vld   <= 1'b0;
                r_burst <= '0;
            end
        end
    end

    assign dout_merge = r_dout;
    assign src_merge  = r_src;
    assign vld_merge  = r_vld;
    assign beat_count = r_beat;

endmodule

// File: tb/tb_leaf_user_rr_merge.sv
// tb/tb_leaf_user_rr_merge.sv - directed bench for leaf_user_rr_merge with MAX_BURST 4 and 1
module tb_leaf_user_rr_merge;

    localparam int NI = 4;
    localparam int PB = 32;
    localparam int SB = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NI*PB-1:0] din;
    logic [NI-1:0]    vld;
    logic             ack_merge;

    logic [NI-1:0] ack4, ack1;
    logic [PB-1:0] dout4, dout1;
    logic [SB-1:0] src4, src1;
    logic          vm4, vm1;
    logic [31:0]   beat4, beat1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    leaf_user_rr_merge #(.NUM_IN(NI), .PAYLOAD_BITS(PB), .SRC_BITS(SB), .MAX_BURST(4), .CNT_BITS(32)) u_b4 (
        .clk(clk), .reset(reset), .din_leaf_interface2user(din), .vld_interface2user(vld),
        .ack_user2interface(ack4), .dout_merge(dout4), .src_merge(src4), .vld_merge(vm4),
        .ack_merge(ack_merge), .beat_count(beat4));

    leaf_user_rr_merge #(.NUM_IN(NI), .PAYLOAD_BITS(PB), .SRC_BITS(SB), .MAX_BURST(1), .CNT_BITS(32)) u_b1 (
        .clk(clk), .reset(reset), .din_leaf_interface2user(din), .vld_interface2user(vld),
        .ack_user2interface(ack1), .dout_merge(dout1), .src_merge(src1), .vld_merge(vm1),
        .ack_merge(ack_merge), .beat_count(beat1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp4 [7] = '{1, 1, 3, 3, 3, 3, 1};
    int exp1 [7] = '{1, 3, 3, 1, 3, 1, 3};

    initial begin
        for (int i = 0; i < NI; i++) din[i*PB +: PB] = 32'(16 + i);
        vld       = '0;
        ack_merge = 1'b1;
        reset     = 1'b1;

        step();
        vld = 4'hF;
        #1;
        chk("rst_ack4", 32'(ack4), 32'h0);
        chk("rst_ack1", 32'(ack1), 32'h0);
        chk("rst_vld", 32'(vm4), 32'h0);
        chk("rst_beat", beat4, 32'h0);
        chk("rst_dout", dout4, 32'h0);
        chk("rst_src", 32'(src4), 32'h0);

        reset = 1'b0;
        #1;
        chk("first_ack4", 32'(ack4), 32'h1);
        chk("first_ack1", 32'(ack1), 32'h1);

        for (int k = 1; k <= 16; k++) begin
            step();
            chk("b4_src", 32'(src4), 32'((k - 1) / 4));
            chk("b4_dout", dout4, 32'(16 + (k - 1) / 4));
            chk("b4_vld", 32'(vm4), 32'h1);
            chk("b1_src", 32'(src1), 32'((k - 1) % 4));
            chk("b1_dout", dout1, 32'(16 + (k - 1) % 4));
            chk("b1_vld", 32'(vm1), 32'h1);
        end
        chk("beat16_b4", beat4, 32'd16);
        chk("beat16_b1", beat1, 32'd16);

        ack_merge = 1'b0;
        #1;
        chk("stall_ack4", 32'(ack4), 32'h0);
        chk("stall_ack1", 32'(ack1), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_ack4", 32'(ack4), 32'h0);
            chk("stall_ack1", 32'(ack1), 32'h0);
            chk("stall_dout4", dout4, 32'h13);
            chk("stall_dout1", dout1, 32'h13);
            chk("stall_vld", 32'(vm4), 32'h1);
            chk("stall_beat", beat4, 32'd16);
        end
        ack_merge = 1'b1;
        #1;
        chk("release_ack4", 32'(ack4), 32'h1);
        step();
        chk("release_src4", 32'(src4), 32'h0);
        chk("release_dout4", dout4, 32'h10);
        chk("release_src1", 32'(src1), 32'h0);
        chk("release_beat", beat4, 32'd17);

        vld = 4'b0100;
        din[2*PB +: PB] = 32'd1;
        #1;
        chk("p2_ack4", 32'(ack4), 32'h4);
        for (int n = 1; n <= 10; n++) begin
            din[2*PB +: PB] = 32'(n);
            step();
            chk("p2_dout4", dout4, 32'(n));
            chk("p2_src4", 32'(src4), 32'h2);
            chk("p2_vld4", 32'(vm4), 32'h1);
            chk("p2_burst4", 32'(u_b4.r_burst), 32'(((n - 1) % 4) + 1));
            chk("p2_dout1", dout1, 32'(n));
        end
        chk("p2_beat", beat4, 32'd27);

        reset = 1'b1;
        din[2*PB +: PB] = 32'h12;
        vld = 4'b1010;
        #2;
        reset = 1'b0;
        #1;
        chk("drop_ack4", 32'(ack4), 32'h2);
        for (int e = 1; e <= 7; e++) begin
            if (e == 3) begin
                vld = 4'b1000;
                #1;
                chk("drop_same_cycle_ack4", 32'(ack4), 32'h8);
            end
            if (e == 4) vld = 4'b1010;
            step();
            chk("drop_src4", 32'(src4), 32'(exp4[e-1]));
            chk("drop_dout4", dout4, 32'(16 + exp4[e-1]));
            chk("drop_src1", 32'(src1), 32'(exp1[e-1]));
        end

        reset = 1'b1;
        #1;
        chk("midrst_vld4", 32'(vm4), 32'h0);
        chk("midrst_vld1", 32'(vm1), 32'h0);
        chk("midrst_beat4", beat4, 32'h0);
        chk("midrst_ack4", 32'(ack4), 32'h0);
        chk("midrst_ack1", 32'(ack1), 32'h0);
        vld = 4'hF;
        step();
        chk("midrst_hold_vld", 32'(vm4), 32'h0);
        reset = 1'b0;
        #1;
        chk("postrst_ack4", 32'(ack4), 32'h1);
        chk("postrst_ack1", 32'(ack1), 32'h1);
        step();
        chk("postrst_src4", 32'(src4), 32'h0);
        chk("postrst_dout4", dout4, 32'h10);
        chk("postrst_beat4", beat4, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
